// File: rtl/ex_stage.sv
// Execute stage: ALU control decode, ALU, branch target and write-register select,
// followed by the EX/MEM pipeline register. pc_src is formed from registered values only.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_dst,
    input  logic [2:0]  alu_op,
    input  logic        alu_src,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] imm,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        branch_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [31:0] branch_pc,
    output logic        zero_out,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  write_reg,
    output logic        pc_src
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic [31:0] target;
    logic [4:0]  dest;

    assign funct = imm[5:0];
    assign shamt = imm[10:6];
    assign alu_b = alu_src ? imm : data2;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            3'b000: alu_ctrl = ALU_ADD;
            3'b001: alu_ctrl = ALU_SUB;
            3'b010: begin
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b100111: alu_ctrl = ALU_NOR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    6'b000000: alu_ctrl = ALU_SLL;
                    6'b000010: alu_ctrl = ALU_SRL;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            3'b011:  alu_ctrl = ALU_AND;
            3'b100:  alu_ctrl = ALU_OR;
            3'b101:  alu_ctrl = ALU_SLT;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_y = 32'd0;
        case (alu_ctrl)
            ALU_AND: alu_y = data1 & alu_b;
            ALU_OR:  alu_y = data1 | alu_b;
            ALU_ADD: alu_y = data1 + alu_b;
            ALU_SLL: alu_y = alu_b << shamt;
            ALU_SRL: alu_y = alu_b >> shamt;
            ALU_NOR: alu_y = ~(data1 | alu_b);
            ALU_SUB: alu_y = data1 - alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(data1) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
    end

    assign alu_zero = (alu_y == 32'd0);
    assign target   = pc_plus4 + {imm[29:0], 2'b00};
    assign dest     = reg_dst ? rd : rt;

    // No enable: the register loads every cycle, reset discards the in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            branch_out     <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            branch_pc      <= 32'd0;
            zero_out       <= 1'b0;
            alu_result     <= 32'd0;
            store_data     <= 32'd0;
            write_reg      <= 5'd0;
        end else begin
            reg_write_out  <= reg_write_in;
            mem_to_reg_out <= mem_to_reg_in;
            branch_out     <= branch_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            branch_pc      <= target;
            zero_out       <= alu_zero;
            alu_result     <= alu_y;
            store_data     <= data2;
            write_reg      <= dest;
        end
    end

    assign pc_src = branch_out & zero_out;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus randomized traffic checked against a
// behavioural model of one execute step, one cycle behind the inputs.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in;
    logic        reg_dst;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic [31:0] pc_plus4, data1, data2, imm;
    logic [4:0]  rt, rd;
    logic        reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out;
    logic [31:0] branch_pc;
    logic        zero_out;
    logic [31:0] alu_result, store_data;
    logic [4:0]  write_reg;
    logic        pc_src;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] e_alu, e_bpc, e_store;
    logic        e_zero, e_pcsrc;
    logic [4:0]  e_wreg, e_ctl;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_dst(reg_dst), .alu_op(alu_op), .alu_src(alu_src),
        .pc_plus4(pc_plus4), .data1(data1), .data2(data2), .imm(imm), .rt(rt), .rd(rd),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .branch_out(branch_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .branch_pc(branch_pc), .zero_out(zero_out), .alu_result(alu_result),
        .store_data(store_data), .write_reg(write_reg), .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] im);
        logic [5:0] fn;
        int         sh;
        fn = im[5:0];
        sh = int'(im[10:6]);
        case (op)
            3'd1: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd2: begin
                if (fn == 6'h22) return a - b;
                if (fn == 6'h24) return a & b;
                if (fn == 6'h25) return a | b;
                if (fn == 6'h27) return ~(a | b);
                if (fn == 6'h2a) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                if (fn == 6'h00) return b << sh;
                if (fn == 6'h02) return b >> sh;
                return a + b;
            end
            default: return a + b;
        endcase
    endfunction

    // Expected register contents after the coming edge, from the inputs currently applied.
    task automatic predict();
        logic [31:0] b;
        if (rst) begin
            e_alu = 0; e_bpc = 0; e_store = 0; e_zero = 0; e_wreg = 0; e_ctl = 0;
        end else begin
            b       = alu_src ? imm : data2;
            e_alu   = alu_model(alu_op, data1, b, imm);
            e_zero  = (e_alu == 0);
            e_bpc   = pc_plus4 + imm * 4;
            e_store = data2;
            e_wreg  = reg_dst ? rd : rt;
            e_ctl   = {reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in};
        end
        e_pcsrc = e_ctl[2] & e_zero;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_alu"},   alu_result, e_alu);
        chk({pfx, "_zero"},  {31'd0, zero_out}, {31'd0, e_zero});
        chk({pfx, "_bpc"},   branch_pc, e_bpc);
        chk({pfx, "_store"}, store_data, e_store);
        chk({pfx, "_wreg"},  {27'd0, write_reg}, {27'd0, e_wreg});
        chk({pfx, "_ctl"},   {27'd0, reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out},
                             {27'd0, e_ctl});
        chk({pfx, "_pcsrc"}, {31'd0, pc_src}, {31'd0, e_pcsrc});
    endtask

    task automatic step(input string pfx);
        predict();
        @(posedge clk);
        #1;
        check_all(pfx);
    endtask

    task automatic clear_inputs();
        {reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in} = 5'd0;
        reg_dst = 0; alu_op = 0; alu_src = 0;
        pc_plus4 = 0; data1 = 0; data2 = 0; imm = 0; rt = 0; rd = 0;
    endtask

    task automatic randomize_inputs();
        logic [5:0] fl [9];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h3f};
        {reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in} = 5'($urandom);
        reg_dst  = 1'($urandom);
        alu_op   = ($urandom_range(0, 2) == 0) ? 3'd2 : 3'($urandom);
        alu_src  = 1'($urandom);
        pc_plus4 = $urandom;
        data1    = ($urandom_range(0, 3) == 0) ? 32'h7fff_fff0 + 32'($urandom_range(0, 31)) : $urandom;
        data2    = ($urandom_range(0, 3) == 0) ? data1 : $urandom;
        imm      = $urandom;
        if ($urandom_range(0, 1) == 1) imm[5:0] = fl[$urandom_range(0, 8)];
        if ($urandom_range(0, 3) == 0) imm = data2;
        rt = 5'($urandom);
        rd = 5'($urandom);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        randomize_inputs();
        step("rst_a");
        step("rst_b");
        rst = 0;

        clear_inputs();
        alu_op = 3'b010; imm = 32'h20; data1 = 5; data2 = 7; reg_dst = 1; rd = 3;
        step("radd");
        chk("radd_const", alu_result, 32'd12);
        chk("radd_wreg_const", {27'd0, write_reg}, 32'd3);

        clear_inputs();
        alu_op = 3'b000; alu_src = 1; data1 = 32'h40; imm = 32'hffff_fffc; rt = 9; mem_read_in = 1;
        step("lw");
        chk("lw_const", alu_result, 32'h3c);
        chk("lw_mrd_const", {31'd0, mem_read_out}, 32'd1);

        clear_inputs();
        alu_op = 3'b010; imm = 32'h2a; data1 = 32'hffff_ffff; data2 = 1;
        step("slt");
        chk("slt_const", alu_result, 32'd1);

        clear_inputs();
        alu_op = 3'b010; imm = (32'd4 << 6); data2 = 1;
        step("sll");
        chk("sll_const", alu_result, 32'h10);

        clear_inputs();
        alu_op = 3'b010; imm = 32'h3f; data1 = 2; data2 = 3;
        step("unk");
        chk("unk_const", alu_result, 32'd5);

        clear_inputs();
        alu_op = 3'b000; data1 = 32'h7fff_ffff; data2 = 1;
        step("wrap");
        chk("wrap_const", alu_result, 32'h8000_0000);

        clear_inputs();
        alu_op = 3'b001; data1 = 32'h1234; data2 = 32'h1234; branch_in = 1; pc_plus4 = 32'h100; imm = 3;
        step("beq");
        chk("beq_bpc_const", branch_pc, 32'h10c);
        chk("beq_pcsrc_const", {31'd0, pc_src}, 32'd1);

        // Mid-stream reset with live inputs must drop the in-flight instruction.
        rst = 1;
        step("midrst");
        chk("midrst_pcsrc_const", {31'd0, pc_src}, 32'd0);
        chk("midrst_alu_const", alu_result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step("rsthold");
        end
        rst = 0;
        randomize_inputs();
        step("rstrel");

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            randomize_inputs();
            step("rand");
            // Fresh inputs between edges must not move the registered-only pc_src.
            randomize_inputs();
            #2;
            chk("rand_pcsrc_hold", {31'd0, pc_src}, {31'd0, e_pcsrc});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in  input  1 each  control bits passed to the memory stage.
REQ-005 reg_dst  input  1  write-register select: 1 selects rd, 0 selects rt.
REQ-006 alu_op  input  3  operation class from decode.
REQ-007 alu_src  input  1  ALU B select: 1 selects imm, 0 selects data2.
REQ-008 pc_plus4  input  32  sequential PC of the instruction.
REQ-009 data1, data2  input  32 each  register operands rs and rt.
REQ-010 imm  input  32  sign-extended immediate; funct = imm[5:0], shamt = imm[10:6].
REQ-011 rt, rd  input  5 each  destination register candidates.
REQ-012 reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out  output  1 each  registered control bits.
REQ-013 branch_pc  output  32  registered branch target.
REQ-014 zero_out  output  1  registered ALU zero flag.
REQ-015 alu_result  output  32  registered ALU result; this is the memory address.
REQ-016 store_data  output  32  registered data2, used as memory write data.
REQ-017 write_reg  output  5  registered destination register.
REQ-018 pc_src  output  1  combinational branch_out AND zero_out.

Function
REQ-019 ALU operand A SHALL be data1.
REQ-020 ALU operand B SHALL be imm when alu_src=1, otherwise data2.
REQ-021 The ALU control code SHALL be decoded from alu_op as follows:
- 000 -> ADD
- 001 -> SUB
- 010 -> decoded from funct (REQ-022)
- 011 -> AND
- 100 -> OR
- 101 -> SLT
- 110, 111 -> ADD
REQ-022 The funct decode SHALL be:
- 100000 -> ADD, 100010 -> SUB
- 100100 -> AND, 100101 -> OR, 100111 -> NOR
- 101010 -> SLT
- 000000 -> SLL, 000010 -> SRL
- any other funct -> ADD
REQ-023 Internal 3-bit control codes SHALL be: AND 000, OR 001, ADD 010, SLL 011, SRL 100, NOR 101, SUB 110, SLT 111.
REQ-024 ADD and SUB SHALL be 32-bit modulo arithmetic with wrap-around and no overflow trap.
REQ-025 SLT SHALL be a signed compare that returns 1 or 0 zero-extended to 32 bits.
REQ-026 SLL and SRL SHALL shift B by shamt (0-31), filling with zeros.
REQ-027 The combinational zero flag SHALL be 1 exactly when the 32-bit ALU result is 0.
REQ-028 The write register SHALL be rd when reg_dst=1, otherwise rt.
REQ-029 The branch target SHALL be pc_plus4 + (imm << 2), truncated to 32 bits, and computed regardless of branch_in.
REQ-030 On each rising clk edge with rst=0, all registered outputs SHALL capture their combinational values, giving a latency of exactly 1 cycle.
REQ-031 The pipeline register SHALL have no stall or enable; it loads every cycle.
REQ-032 pc_src SHALL be derived only from registered values, so it changes only after a clock edge.

Reset
REQ-033 When rst=1 at a rising clk edge, every registered output SHALL become 0, and therefore pc_src=0.
REQ-034 While rst is held high, outputs SHALL stay 0 regardless of inputs.
REQ-035 Inputs present in the cycle rst deasserts SHALL be captured at the next edge.
REQ-036 A reset asserted mid-operation SHALL discard the in-flight instruction.

Verification
REQ-037 R-type add: alu_op=010, funct=100000, data1=5, data2=7, reg_dst=1, rd=3 -> after 1 edge alu_result=12, zero_out=0, write_reg=3.
REQ-038 beq taken: alu_op=001, data1=data2=0x1234, branch_in=1, pc_plus4=0x100, imm=3 -> branch_pc=0x10C, zero_out=1, pc_src=1.
REQ-039 lw: alu_op=000, alu_src=1, data1=0x40, imm=0xFFFFFFFC, reg_dst=0, rt=9, mem_read_in=1 -> alu_result=0x3C, write_reg=9, mem_read_out=1.
REQ-040 slt signed: funct=101010, data1=0xFFFFFFFF, data2=1 -> alu_result=1; sll with data2=1, shamt=4 -> alu_result=0x10.
REQ-041 Reset mid-stream: after REQ-038 completes, assert rst for 1 edge -> all outputs 0 and pc_src=0.
REQ-042 Unknown funct 111111 with data1=2, data2=3 -> alu_result=5 (ADD); add 0x7FFFFFFF+1 -> 0x80000000 with no flag.
